fifo_wr_arb: RTL
================

# fifo_wr_arb

Packet-aware round-robin write arbiter and occupancy controller for the 16-entry shared synchronous FIFO. Up to NUM_REQ producers present valid/ready packet streams. The block grants one producer at a time, holds the grant until that producer's last beat, and drives the FIFO write port. It also gates consumer pops and keeps the authoritative occupancy count, full flag and empty flag.

## Interface
- DATA_WIDTH, 8, width of one FIFO word
- NUM_REQ, 4, number of producers (2..8)
- DEPTH, 16, FIFO capacity in words
- AF_LEVEL, 12, almost-full threshold (used only with FIFO_WR_ARB_AF_EN)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-producer beat valid
- req_last  in  NUM_REQ  per-producer last-beat-of-packet marker
- req_data  in  NUM_REQ*DATA_WIDTH  producer words; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-producer accept, one-hot or zero
- pop_req  in  1  consumer requests one word
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  word to FIFO
- fifo_rd_en  out  1  FIFO read strobe (pop granted)
- owner  out  clog2(NUM_REQ)  index of the current or last grant holder
- count  out  clog2(DEPTH)+1  words held, 0..DEPTH
- full, empty  out  1  count==DEPTH, count==0
- almost_full  out  1  count>=AF_LEVEL (macro-dependent)

## Operation
- FSM states:
  - ARB: no producer owns the port.
  - HOLD: producer `owner` owns the port until its last beat is accepted.
- Space condition: space = !full | fifo_rd_en.
- Pop gating:
  - fifo_rd_en = pop_req & !empty & !rst (combinational).
  - A pop at count 0 is ignored, even when a push is accepted in the same cycle.
- ARB state:
  - Candidate = first i with req_valid[i], searched from ptr+1 upward, modulo NUM_REQ.
  - If space, req_ready[candidate]=1 (combinational) and the beat is accepted.
  - Accept with req_last=1 (single-beat packet): stay in ARB, ptr<=candidate.
  - Accept with req_last=0: go to HOLD, owner<=candidate.
  - If no valid request, or no space: no ready, no state change.
- HOLD state:
  - Only req_ready[owner] can assert, and only when space.
  - Other producers are blocked regardless of their valid.
  - Accepted beat with req_last=1: go to ARB, ptr<=owner.
  - Owner dropping req_valid mid-packet keeps HOLD; there is no timeout.
- Write port:
  - fifo_wr_en = |(req_valid & req_ready).
  - fifo_wr_data = selected producer's word, or 0 when idle.
  - Both are combinational, same cycle as the accept.
- Occupancy:
  - count next = count + push − pop.
  - Push and pop in the same cycle leave count unchanged, including at full (space via pop) and at count 1.
  - count never exceeds DEPTH and never underflows.
- owner mirrors ptr in ARB and the holder in HOLD.

## Timing
- Reset values: state ARB, ptr=NUM_REQ−1 (producer 0 has first priority), owner=NUM_REQ−1, count=0, empty=1, full=0, almost_full=0.
- Combinational outputs during a reset cycle: req_ready=0, fifo_wr_en=0, fifo_rd_en=0.
- rst asserted mid-packet drops HOLD immediately. The FIFO contents are considered discarded; count returns to 0 on the next edge.
- Accept-to-write latency 0: the word is written at the same edge it is accepted.
- full, empty and count are registered. They reflect a push or pop one edge later.
- A word pushed at edge t is poppable from cycle t+1.
- Ready is never asserted in a cycle where valid is low; no speculative ready.
- No combinational path from pop_req to req_ready except through the space term (fifo_rd_en). This path is permitted.
- Fairness: a continuously requesting producer is granted within NUM_REQ−1 packets of the others.

## Configuration
- FIFO_WR_ARB_AF_EN defined:
  - almost_full is a registered flag, set when next count >= AF_LEVEL, updated with count.
  - New ARB grants are withheld while almost_full=1. A HOLD owner may still finish its packet into the remaining space.
- FIFO_WR_ARB_AF_EN undefined:
  - almost_full is tied to 0.
  - Grants depend only on space.

## Test plan
- Reset then idle: after rst high for 2 cycles → count=0, empty=1, full=0, req_ready=0, fifo_wr_en=0; pop_req=1 → fifo_rd_en=0.
- Round-robin: all 4 producers hold valid single-beat packets (last=1) for 8 cycles → grant order 0,1,2,3,0,1,2,3; count=8 after cycle 8.
- Packet lock: producer 2 sends a 3-beat packet while producer 1 is valid → req_ready[1]=0 for all 3 beats, then producer 3 is granted (ptr=2), not producer 1.
- Full boundary: fill to count=16 → full=1, all ready low. Apply a push and pop in the same cycle → accepted, count stays 16. Pop only → count=15.
- Empty boundary: at count=0, push and pop in the same cycle → fifo_rd_en=0, count=1 next cycle. Pop next cycle → fifo_rd_en=1, count=0.
- Mid-packet reset: rst asserted during beat 2 of a 4-beat packet → next cycle state ARB, count=0, producer 0 has top priority. With FIFO_WR_ARB_AF_EN and AF_LEVEL=12: at count=12, a new ARB request is not granted.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Packet-aware round-robin write arbiter and occupancy controller for a shared FIFO.
// Optional almost-full grant throttling is enabled by defining FIFO_WR_ARB_AF_EN.
module fifo_wr_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          pop_req,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_rd_en,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || AF_LEVEL > DEPTH) begin : g_param_check
    $fatal(1, "fifo_wr_arb: unsupported parameter combination");
  end

  typedef enum logic [0:0] {StArb, StHold} state_e;

  state_e        state_q, state_d;
  // In StArb owner_q doubles as the round-robin pointer (last grant holder).
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, af_q;

  logic          space, grant_ok, push;
  logic          cand_found;
  logic [IW-1:0] cand, sel;

  assign fifo_rd_en = pop_req & ~empty_q & ~rst;
  assign space      = ~full_q | fifo_rd_en;

`ifdef FIFO_WR_ARB_AF_EN
  assign grant_ok    = space & ~af_q;
  assign almost_full = af_q;
`else
  assign grant_ok    = space;
  assign almost_full = 1'b0;
`endif

  // First valid requester after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    cand_found = 1'b0;
    cand       = owner_q;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(owner_q) + k) % int'(NUM_REQ));
      if (!cand_found && req_valid[idx]) begin
        cand_found = 1'b1;
        cand       = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel       = owner_q;
    state_d   = state_q;
    owner_d   = owner_q;
    if (!rst) begin
      unique case (state_q)
        StArb: begin
          if (cand_found && grant_ok) begin
            req_ready[cand] = 1'b1;
            sel             = cand;
            owner_d         = cand;
            if (!req_last[cand]) state_d = StHold;
          end
        end
        StHold: begin
          if (req_valid[owner_q] && space) begin
            req_ready[owner_q] = 1'b1;
            if (req_last[owner_q]) state_d = StArb;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  assign push         = |(req_valid & req_ready);
  assign fifo_wr_en   = push;
  assign fifo_wr_data = push ? req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    unique case ({push, fifo_rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StArb;
      owner_q <= IW'(NUM_REQ - 1);
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= CW'(AF_LEVEL));
    end
  end

  assign owner = owner_q;
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule
